// File: rtl/pc_pkg.sv
// Shared definitions for the RiSC-16 program counter unit: next-PC select
// encodings, default vectors and the interrupt state type.
package pc_pkg;

    localparam logic [2:0] MODE_SEQ  = 3'b000;
    localparam logic [2:0] MODE_BR   = 3'b001;
    localparam logic [2:0] MODE_JMP  = 3'b010;
    localparam logic [2:0] MODE_CALL = 3'b011;
    localparam logic [2:0] MODE_RET  = 3'b100;
    localparam logic [2:0] MODE_RETI = 3'b101;

    localparam int unsigned DEF_RESET_VEC = 0;
    localparam int unsigned DEF_IRQ_VEC   = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ISR  = 1'b1
    } isr_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a pop when empty leaves the state alone. Both events raise a one-cycle pulse.
module pc_ras #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         ovf,
    output logic         udf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rd_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          full;

    // wp_q points at the next free slot, so the newest entry sits just below it.
    // When the stack is full, wp_q also points at the oldest entry.
    always_comb begin
        full   = (cnt_q == CW'(DEPTH));
        empty  = (cnt_q == '0);
        rd_idx = (wp_q == '0) ? PW'(DEPTH - 1) : wp_q - PW'(1);
        top    = mem_q[rd_idx];
        wp_d   = wp_q;
        cnt_d  = cnt_q;
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
        if (push) begin
            wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + CW'(1);
        end else if (pop) begin
            if (empty) begin
                udf_d = 1'b1;
            end else begin
                wp_d  = rd_idx;
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= push_data;
    end

    assign ovf = ovf_q;
    assign udf = udf_q;

endmodule

// File: rtl/pc_unit.sv
// RiSC-16 program counter: next-PC selection, a return-address stack, fetch stall,
// and single-level interrupt entry and exit with an acknowledge pulse.
module pc_unit
    import pc_pkg::*;
#(
    parameter int          PC_W      = 16,
    parameter int          IMM_W     = 7,
    parameter int          RAS_DEPTH = 4,
    parameter int unsigned RESET_VEC = DEF_RESET_VEC,
    parameter int unsigned IRQ_VEC   = DEF_IRQ_VEC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [2:0]        mode,
    input  logic [PC_W-1:0]   alu_out,
    input  logic [IMM_W-1:0]  imm,
    input  logic              irq,
    output logic [PC_W-1:0]   pc,
    output logic              irq_ack,
    output logic              in_isr,
    output logic              ras_ovf,
    output logic              ras_udf
);

    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_VEC);
    localparam logic [PC_W-1:0] IRQ_PC = PC_W'(IRQ_VEC);

    isr_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, epc_q, epc_d;
    logic [PC_W-1:0] npc, pc_inc, ras_top;
    logic            ack_q, ack_d;
    logic            ras_push, ras_pop, ras_empty;
    logic            take_irq, reti_exit;

    always_comb begin
        pc_inc    = pc_q + PC_W'(1);
        npc       = pc_inc;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        reti_exit = 1'b0;
        case (mode)
            MODE_BR:   npc = pc_inc + {{(PC_W - IMM_W){imm[IMM_W-1]}}, imm};
            MODE_JMP:  npc = alu_out;
            MODE_CALL: begin
                npc      = alu_out;
                ras_push = !stall;
            end
            MODE_RET: begin
                npc     = ras_empty ? alu_out : ras_top;
                ras_pop = !stall;
            end
            MODE_RETI: begin
                if (state_q == ST_ISR) begin
                    npc       = epc_q;
                    reti_exit = 1'b1;
                end
            end
            default: ;
        endcase
        take_irq = (state_q == ST_IDLE) && irq && !stall;
    end

    // The redirect always completes; an interrupt taken in the same cycle
    // saves that redirect target as the return point.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        ack_d   = 1'b0;
        if (!stall) begin
            pc_d = npc;
            if (take_irq) begin
                state_d = ST_ISR;
                epc_d   = npc;
                pc_d    = IRQ_PC;
                ack_d   = 1'b1;
            end else if (reti_exit) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RST_PC;
            epc_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            ack_q   <= ack_d;
        end
    end

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .ovf       (ras_ovf),
        .udf       (ras_udf)
    );

    assign pc      = pc_q;
    assign irq_ack = ack_q;
    assign in_isr  = (state_q == ST_ISR);

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the PC, stack and interrupt state.
module tb_pc_unit;

    localparam int          DEPTH = 4;
    localparam logic [15:0] RVEC  = 16'h0000;
    localparam logic [15:0] IVEC  = 16'h0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        irq = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [15:0] alu_out = 16'h0;
    logic [6:0]  imm = 7'h0;
    logic [15:0] pc;
    logic        irq_ack, in_isr, ras_ovf, ras_udf;

    pc_unit #(
        .PC_W      (16),
        .IMM_W     (7),
        .RAS_DEPTH (DEPTH),
        .RESET_VEC (0),
        .IRQ_VEC   (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .mode    (mode),
        .alu_out (alu_out),
        .imm     (imm),
        .irq     (irq),
        .pc      (pc),
        .irq_ack (irq_ack),
        .in_isr  (in_isr),
        .ras_ovf (ras_ovf),
        .ras_udf (ras_udf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_pc = 16'h0;
    logic [15:0] m_epc = 16'h0;
    logic        m_isr = 1'b0, m_ack = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
    logic [15:0] m_ras[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic s, input logic [2:0] md,
                         input logic [15:0] alu, input logic [6:0] im, input logic iq);
        logic [15:0] npc;
        logic        was_isr;
        int          off;
        if (!r) begin
            m_pc = RVEC; m_epc = 16'h0; m_isr = 1'b0;
            m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
            m_ras.delete();
            return;
        end
        m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        if (s) return;
        was_isr = m_isr;
        npc = m_pc + 16'd1;
        case (md)
            3'd1: begin
                off = im[6] ? int'(im) - 128 : int'(im);
                npc = m_pc + 16'd1 + 16'(off);
            end
            3'd2: npc = alu;
            3'd3: begin
                npc = alu;
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(m_pc + 16'd1);
            end
            3'd4: begin
                if (m_ras.size() == 0) begin
                    npc = alu;
                    m_udf = 1'b1;
                end else begin
                    npc = m_ras.pop_back();
                end
            end
            3'd5: begin
                if (m_isr) begin
                    npc = m_epc;
                    m_isr = 1'b0;
                end
            end
            default: ;
        endcase
        if (!was_isr && iq) begin
            m_epc = npc; m_pc = IVEC; m_isr = 1'b1; m_ack = 1'b1;
        end else begin
            m_pc = npc;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [2:0] md,
                        input logic [15:0] alu, input logic [6:0] im, input logic iq);
        @(negedge clk);
        rst_n = r; stall = s; mode = md; alu_out = alu; imm = im; irq = iq;
        @(posedge clk);
        model(r, s, md, alu, im, iq);
        #1;
        chk("pc", pc, m_pc);
        chk("irq_ack", irq_ack, m_ack);
        chk("in_isr", in_isr, m_isr);
        chk("ras_ovf", ras_ovf, m_ovf);
        chk("ras_udf", ras_udf, m_udf);
    endtask

    initial begin
        step(0, 0, 3'd0, 16'h0, 7'h0, 0);
        step(0, 0, 3'd0, 16'h0, 7'h0, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_isr", in_isr, 32'h0);

        for (int i = 0; i < 3; i++) step(1, 0, 3'd0, 16'h0, 7'h0, 0);
        chk("seq3", pc, 32'h3);
        step(1, 1, 3'd3, 16'h0999, 7'h0, 1);
        step(1, 1, 3'd4, 16'h0999, 7'h0, 1);
        chk("stall_hold", pc, 32'h3);

        step(1, 0, 3'd2, 16'h0010, 7'h0, 0);
        step(1, 0, 3'd1, 16'h0, 7'h7E, 0);
        chk("br_neg", pc, 32'h000F);
        step(1, 0, 3'd2, 16'hFFFF, 7'h0, 0);
        step(1, 0, 3'd0, 16'h0, 7'h0, 0);
        chk("seq_wrap", pc, 32'h0);

        step(1, 0, 3'd2, 16'h0005, 7'h0, 0);
        step(1, 0, 3'd3, 16'h0100, 7'h0, 0);
        chk("call_tgt", pc, 32'h0100);
        step(1, 0, 3'd4, 16'h0300, 7'h0, 0);
        chk("ret_addr", pc, 32'h0006);
        chk("ret_no_udf", ras_udf, 32'h0);
        step(1, 0, 3'd4, 16'h0200, 7'h0, 0);
        chk("ret_fallback", pc, 32'h0200);
        chk("ret_udf", ras_udf, 32'h1);

        step(1, 0, 3'd2, 16'h0010, 7'h0, 0);
        step(1, 0, 3'd3, 16'h0020, 7'h0, 0);
        step(1, 0, 3'd3, 16'h0030, 7'h0, 0);
        step(1, 0, 3'd3, 16'h0040, 7'h0, 0);
        step(1, 0, 3'd3, 16'h0050, 7'h0, 0);
        chk("call4_no_ovf", ras_ovf, 32'h0);
        step(1, 0, 3'd3, 16'h0060, 7'h0, 0);
        chk("call5_ovf", ras_ovf, 32'h1);
        step(1, 0, 3'd4, 16'h0, 7'h0, 0);
        chk("ret_51", pc, 32'h0051);
        step(1, 0, 3'd4, 16'h0, 7'h0, 0);
        chk("ret_41", pc, 32'h0041);
        step(1, 0, 3'd4, 16'h0, 7'h0, 0);
        chk("ret_31", pc, 32'h0031);
        step(1, 0, 3'd4, 16'h0, 7'h0, 0);
        chk("ret_21", pc, 32'h0021);
        step(1, 0, 3'd4, 16'h0077, 7'h0, 0);
        chk("ret5_udf", ras_udf, 32'h1);

        step(1, 0, 3'd2, 16'h0030, 7'h0, 0);
        step(1, 0, 3'd1, 16'h0, 7'h04, 1);
        chk("irq_vec", pc, 32'h0001);
        chk("irq_ack_pulse", irq_ack, 32'h1);
        chk("irq_in_isr", in_isr, 32'h1);
        step(1, 0, 3'd0, 16'h0, 7'h0, 1);
        chk("irq_nested_ignored", irq_ack, 32'h0);
        chk("irq_isr_seq", pc, 32'h0002);
        step(1, 0, 3'd5, 16'h0, 7'h0, 1);
        chk("reti_epc", pc, 32'h0035);
        chk("reti_idle", in_isr, 32'h0);
        step(1, 0, 3'd0, 16'h0, 7'h0, 0);

        step(1, 0, 3'd3, 16'h0100, 7'h0, 0);
        step(1, 0, 3'd3, 16'h0110, 7'h0, 0);
        step(1, 0, 3'd3, 16'h0120, 7'h0, 1);
        chk("pre_rst_isr", in_isr, 32'h1);
        step(0, 0, 3'd3, 16'h0130, 7'h0, 1);
        chk("mid_isr_rst_pc", pc, 32'h0);
        chk("mid_isr_rst_isr", in_isr, 32'h0);
        step(1, 0, 3'd4, 16'h0040, 7'h0, 0);
        chk("post_rst_udf", ras_udf, 32'h1);
        chk("post_rst_pc", pc, 32'h0040);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 4) == 0),
                 3'($urandom_range(0, 7)),
                 16'($urandom),
                 7'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the RiSC-16 core family.
- Holds the registered fetch address and selects the next PC: sequential, PC-relative branch, absolute jump, call, return, or return-from-interrupt.
- Adds what a bare PC lacks: fetch stall, a circular return-address stack (RAS), and a single-level interrupt entry/exit state machine with an acknowledge handshake.
- Sits between the decoder/ALU and the instruction memory address port.

Parameters:
- PC_W, 16: PC and target width in bits.
- IMM_W, 7: branch offset width; the offset is sign-extended to PC_W.
- RAS_DEPTH, 4: return-address stack entries; legal range 2..16.
- RESET_VEC, 0: PC value loaded at reset.
- IRQ_VEC, 1: PC value loaded on interrupt entry.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  hold PC, RAS and interrupt state this cycle
- mode  in  3  next-PC select: 000 SEQ, 001 BR, 010 JMP, 011 CALL, 100 RET, 101 RETI; 110/111 behave as SEQ
- alu_out  in  PC_W  absolute target for JMP/CALL, fallback target for RET
- imm  in  IMM_W  signed branch offset
- irq  in  1  level interrupt request, held by the source until irq_ack
- pc  out  PC_W  current fetch address (registered)
- irq_ack  out  1  one-cycle pulse: interrupt taken
- in_isr  out  1  handler active
- ras_ovf  out  1  one-cycle pulse: push overwrote the oldest entry
- ras_udf  out  1  one-cycle pulse: pop on an empty stack

Behaviour:
- Reset (rst_n=0 at a clk edge): pc=RESET_VEC, RAS count=0, RAS pointer=0, epc=0, in_isr=0, irq_ack=0, ras_ovf=0, ras_udf=0. Reset overrides every other input; reset mid-ISR or with a full RAS clears everything.
- Priority each cycle: reset > stall > mode redirect plus irq entry.
- stall=1: every register holds, all pulses are 0, irq is not taken.
- Next-PC computation (comb), all arithmetic mod 2^PC_W:
  - SEQ: npc = pc+1.
  - BR: npc = pc+1+sext(imm).
  - JMP: npc = alu_out.
  - CALL: npc = alu_out; push pc+1.
  - RET: npc = top of RAS and pop. If count=0: npc = alu_out and ras_udf=1.
  - RETI with in_isr=1: npc = epc, in_isr <= 0. RETI with in_isr=0 behaves as SEQ.
- RAS: circular buffer of RAS_DEPTH x PC_W with a write pointer and a count in 0..RAS_DEPTH.
  - Push at count=RAS_DEPTH overwrites the oldest entry; count stays at RAS_DEPTH; ras_ovf=1.
  - Pointer wraps modulo RAS_DEPTH.
- Interrupt FSM states: IDLE (in_isr=0) and ISR (in_isr=1).
  - IDLE->ISR when irq=1 and stall=0: the current mode action completes, including any RAS push/pop. epc <= computed npc, pc <= IRQ_VEC, irq_ack=1 for exactly that cycle.
  - In ISR, irq is ignored (no nesting).
  - ISR->IDLE on RETI with stall=0.
  - RETI and irq in the same cycle while in ISR: exit is taken, and irq is evaluated again the next cycle.
- Update latency: pc updates one clk after inputs are sampled. pc is always the registered value and is never driven combinationally.

Decomposition:
- Shared package pc_pkg: mode encodings (MODE_SEQ..MODE_RETI) and the default vector constants.
- One sub-module, pc_ras: parametrised circular stack with push/pop/top/count and ovf/udf pulses.
- The FSM and npc mux stay in pc_unit.

Test Plan:
- Reset, then 3 cycles of SEQ -> pc = 0, 1, 2, 3. Then stall=1 for 2 cycles -> pc holds 3 and the RAS is unchanged.
- At pc=0x0010, BR with imm=7'h7E (-2) -> pc=0x000F. At pc=0xFFFF, SEQ -> pc=0x0000 (wrap).
- At pc=0x0005, CALL with alu_out=0x0100 -> pc=0x0100. Then RET -> pc=0x0006, ras_udf=0. A second RET with alu_out=0x0200 -> pc=0x0200 and ras_udf pulses.
- 5 CALLs from pc=0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH=4 -> ras_ovf pulses on the 5th. 4 RETs return 0x51, 0x41, 0x31, 0x21; the 5th RET raises ras_udf.
- At pc=0x0030, irq=1 with BR imm=4 -> next pc=IRQ_VEC, epc=0x0035, irq_ack pulses once, in_isr=1. A second irq in ISR is ignored. RETI -> pc=0x0035, in_isr=0.
- Assert reset while in_isr=1 and RAS count=3 -> pc=RESET_VEC, in_isr=0. A subsequent RET hits underflow (ras_udf=1).
